sprite_scan_counter: RTL and testbench

Parametrised 2-D pixel scan generator; successor to the single-width screen and sprite address counters. On a start pulse it walks a WIDTH x HEIGHT rectangle in raster order, producing the linear ROM address and the matching on-screen coordinate each step, with stall support and a one-cycle done pulse. It sits between the drawing FSM and the VGA adapter: sprite/background ROM address on one side, plot x/y on the other.

---
 rtl/game_pkg.sv | 8 +
 rtl/scan_axis_counter.sv | 19 +
 rtl/sprite_scan_counter.sv | 82 ++++++++
 tb/tb_sprite_scan_counter.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// game_pkg: screen geometry constants and the scan state encoding shared by the drawing blocks.
package game_pkg;
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int SX_W     = 8;
    localparam int SY_W     = 7;
    typedef enum logic [1:0] {IDLE, SCAN, DONE} scan_state_t;
endpackage

// File: rtl/scan_axis_counter.sv
// scan_axis_counter: 0..LIMIT-1 counter with enable, synchronous clear and terminal-count flag.
module scan_axis_counter #(
    parameter int LIMIT = 40,
    parameter int W     = (LIMIT > 1) ? $clog2(LIMIT) : 1
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         last
);
    localparam logic [W-1:0] MAX = W'(LIMIT - 1);
    assign last = cnt == MAX;
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en) cnt <= last ? '0 : cnt + 1'b1;
endmodule

// File: rtl/sprite_scan_counter.sv
// sprite_scan_counter: raster walk of a WIDTH x HEIGHT rectangle giving ROM address and screen x/y.
// Define SPRITE_SCAN_MIRROR_EN to add the mirror_x port (horizontally flipped ROM addressing).
module sprite_scan_counter #(
    parameter int WIDTH  = 40,
    parameter int HEIGHT = 40,
    parameter int ADDR_W = 11,
    parameter int SX_W   = game_pkg::SX_W,
    parameter int SY_W   = game_pkg::SY_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              advance,
    input  logic [SX_W-1:0]   org_x,
    input  logic [SY_W-1:0]   org_y,
`ifdef SPRITE_SCAN_MIRROR_EN
    input  logic              mirror_x,
`endif
    output logic [ADDR_W-1:0] addr,
    output logic [SX_W-1:0]   screen_x,
    output logic [SY_W-1:0]   screen_y,
    output logic              valid,
    output logic              busy,
    output logic              done
);
    import game_pkg::*;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    scan_state_t state, state_nx;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [ADDR_W-1:0] row_base;
    logic [SX_W-1:0] ox;
    logic [SY_W-1:0] oy;
    logic col_last, row_last, launch, step, row_step, final_px;
    assign launch   = state == IDLE && start;
    assign step     = state == SCAN && advance;
    assign final_px = col_last && row_last;
    assign row_step = step && col_last && !row_last;
    always_comb begin
        state_nx = state;
        valid    = state == SCAN;
        busy     = state != IDLE;
        done     = state == DONE;
        if (launch) state_nx = SCAN;
        else if (step && final_px) state_nx = DONE;
        else if (state == DONE) state_nx = IDLE;
    end
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) state <= IDLE;
        else state <= state_nx;
    // counters stop on the final pixel so addr/screen hold it through DONE and IDLE
    scan_axis_counter #(.LIMIT(WIDTH), .W(CW)) u_col (
        .clk(clk), .resetn(resetn), .clr(launch), .en(step && !final_px), .cnt(col), .last(col_last)
    );
    scan_axis_counter #(.LIMIT(HEIGHT), .W(RW)) u_row (
        .clk(clk), .resetn(resetn), .clr(launch), .en(row_step), .cnt(row), .last(row_last)
    );
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            ox       <= '0;
            oy       <= '0;
            row_base <= '0;
        end else if (launch) begin
            ox       <= org_x;
            oy       <= org_y;
            row_base <= '0;
        end else if (row_step) begin
            row_base <= row_base + ADDR_W'(WIDTH);
        end
    assign screen_x = ox + SX_W'(col);
    assign screen_y = oy + SY_W'(row);
`ifdef SPRITE_SCAN_MIRROR_EN
    logic mir;
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) mir <= 1'b0;
        else if (launch) mir <= mirror_x;
    assign addr = row_base + (mir ? ADDR_W'(WIDTH - 1) - ADDR_W'(col) : ADDR_W'(col));
`else
    assign addr = row_base + ADDR_W'(col);
`endif
endmodule

// File: tb/tb_sprite_scan_counter.sv
// tb_sprite_scan_counter: table-driven and randomized scans of 4x3, 40x40, 1x1 and 4x1 instances.
module tb_sprite_scan_counter;
    logic clk = 1'b0, resetn = 1'b1, start = 1'b0, advance = 1'b0;
    logic [7:0] org_x = '0;
    logic [6:0] org_y = '0;
`ifdef SPRITE_SCAN_MIRROR_EN
    logic mirror_x = 1'b0;
    localparam bit MIR_EN = 1'b1;
`else
    localparam bit MIR_EN = 1'b0;
`endif
    logic [10:0] a [4];
    logic [7:0] sx [4];
    logic [6:0] sy [4];
    logic v [4], b [4], d [4];
    int checks = 0, errors = 0;
    localparam int WS [4] = '{4, 40, 1, 4};
    localparam int HS [4] = '{3, 40, 1, 1};
    always #10 clk = ~clk;
    for (genvar g = 0; g < 4; g++) begin : g_dut
        sprite_scan_counter #(.WIDTH(WS[g]), .HEIGHT(HS[g])) dut (
            .clk(clk), .resetn(resetn), .start(start), .advance(advance),
            .org_x(org_x), .org_y(org_y),
`ifdef SPRITE_SCAN_MIRROR_EN
            .mirror_x(mirror_x),
`endif
            .addr(a[g]), .screen_x(sx[g]), .screen_y(sy[g]),
            .valid(v[g]), .busy(b[g]), .done(d[g])
        );
    end
    typedef struct {
        int sel;
        int ox;
        int oy;
        bit mir;
        int mode;
        bit restart;
        int exp_done;
    } vec_t;
    function automatic logic [28:0] obs(int s);
        return {v[s], b[s], d[s], a[s], sx[s], sy[s]};
    endfunction
    // expected {valid,busy,done,addr,x,y} while pixel p (raster index) is presented
    function automatic logic [28:0] pix(int p, int w, int ox, int oy, bit mir);
        int r = p / w;
        int c = p % w;
        int ad = mir ? r * w + (w - 1 - c) : p;
        return {3'b110, 11'(ad), 8'(ox + c), 7'(oy + r)};
    endfunction
    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask
    task automatic do_reset();
        resetn = 1'b0;
        start = 1'b0;
        advance = 1'b0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask
    task automatic run_scan(vec_t t, bit rst_first);
        int w = WS[t.sel];
        int n = WS[t.sel] * HS[t.sel];
        int p = 0;
        int cyc = 0;
        bit mir = t.mir && MIR_EN;
        logic [28:0] fin;
        if (rst_first) do_reset();
        org_x = 8'(t.ox);
        org_y = 7'(t.oy);
`ifdef SPRITE_SCAN_MIRROR_EN
        mirror_x = t.mir;
`endif
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (p < n && cyc < 5000) begin
            chk("pixel", 32'(obs(t.sel)), 32'(pix(p, w, t.ox, t.oy, mir)));
            advance = t.mode == 0 ? 1'b1 : t.mode == 1 ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'($urandom_range(0, 1));
            if (t.restart) begin
                start = 1'($urandom_range(0, 1));
                org_x = 8'($urandom);
                org_y = 7'($urandom);
            end
            @(negedge clk);
            cyc++;
            if (advance) p++;
        end
        advance = 1'b0;
        start = t.restart;
        chk("scan_len", 32'(p), 32'(n));
        if (t.exp_done >= 0) chk("done_cycle", 32'(cyc), 32'(t.exp_done));
        fin = pix(n - 1, w, t.ox, t.oy, mir);
        chk("done_pulse", 32'(obs(t.sel)), 32'({3'b011, fin[25:0]}));
        @(negedge clk);
        start = 1'b0;
        chk("idle", 32'(obs(t.sel)), 32'({3'b000, fin[25:0]}));
        @(negedge clk);
        chk("idle_hold", 32'(obs(t.sel)), 32'({3'b000, fin[25:0]}));
    endtask
    initial begin
        vec_t tbl [$];
        vec_t rv;
        tbl.push_back('{sel: 0, ox: 10, oy: 20, mir: 0, mode: 0, restart: 0, exp_done: 12});
        tbl.push_back('{sel: 0, ox: 10, oy: 20, mir: 0, mode: 1, restart: 0, exp_done: 24});
        tbl.push_back('{sel: 0, ox: 10, oy: 20, mir: 0, mode: 0, restart: 1, exp_done: 12});
        tbl.push_back('{sel: 0, ox: 150, oy: 118, mir: 0, mode: 2, restart: 1, exp_done: -1});
        tbl.push_back('{sel: 2, ox: 159, oy: 119, mir: 0, mode: 0, restart: 0, exp_done: 1});
        tbl.push_back('{sel: 3, ox: 158, oy: 0, mir: 0, mode: 0, restart: 0, exp_done: 4});
        tbl.push_back('{sel: 3, ox: 5, oy: 127, mir: 0, mode: 1, restart: 1, exp_done: 8});
        if (MIR_EN) tbl.push_back('{sel: 0, ox: 10, oy: 20, mir: 1, mode: 0, restart: 0, exp_done: 12});
        #1 resetn = 1'b0;
        #1;
        for (int s = 0; s < 4; s++) chk("reset_state", 32'(obs(s)), 32'd0);
        for (int i = 0; i < tbl.size(); i++) run_scan(tbl[i], 1'b1);
        for (int i = 0; i < 4; i++) begin
            rv = '{sel: 0, ox: int'($urandom_range(0, 255)), oy: int'($urandom_range(0, 127)),
                   mir: 1'($urandom_range(0, 1)), mode: 2, restart: 1, exp_done: -1};
            run_scan(rv, 1'b1);
        end
        do_reset();
        org_x = 8'd3;
        org_y = 7'd4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        advance = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("pre_reset", 32'(obs(1)), 32'(pix(i, 40, 3, 4, 1'b0)));
            @(negedge clk);
        end
        chk("pixel5", 32'(obs(1)), 32'(pix(5, 40, 3, 4, 1'b0)));
        resetn = 1'b0;
        #1;
        chk("async_reset", 32'(obs(1)), 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("reset_hold", 32'(obs(1)), 32'd0);
        end
        resetn = 1'b1;
        @(negedge clk);
        chk("after_reset", 32'(obs(1)), 32'd0);
        advance = 1'b0;
        @(negedge clk);
        run_scan('{sel: 1, ox: 60, oy: 70, mir: 0, mode: 0, restart: 0, exp_done: 1600}, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
